// File: rtl/fp_norm_pkg.sv
// Shared definitions for the FP normaliser: width helper, default
// sizes and the stage payload carried between LZC and shift stages.
package fp_norm_pkg;

    function automatic int clog2(input int value);
        int r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    localparam int DEF_WIDTH = 25;
    localparam int DEF_EXP_W = 8;
    localparam int DEF_LZC_W = clog2(DEF_WIDTH);

    // Payload for the default single-precision post-add configuration;
    // the top rebuilds the same layout at its own parameter widths.
    typedef struct packed {
        logic [DEF_WIDTH-1:0] mant;
        logic [DEF_EXP_W-1:0] exp;
        logic [DEF_LZC_W-1:0] lzc;
        logic                 zero;
    } norm_payload_t;

endpackage

// File: rtl/fp_normalize_pipe_lzc.sv
// Binary-tree leading-zero counter.
// Ports: mant in, lzc out (zeros above highest set bit), all_zero out.
module lzc_tree
    import fp_norm_pkg::*;
#(
    parameter int WIDTH = 25,
    parameter int LZC_W = clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] mant,
    output logic [LZC_W-1:0] lzc,
    output logic             all_zero
);

    localparam int LVLS  = clog2(WIDTH);
    localparam int PAD_W = 1 << LVLS;

    logic [PAD_W-1:0] nz  [0:LVLS];
    logic [LZC_W-1:0] cnt [0:LVLS][0:PAD_W-1];

    always_comb begin
        for (int l = 0; l <= LVLS; l++) begin
            nz[l] = '0;
            for (int i = 0; i < PAD_W; i++) cnt[l][i] = '0;
        end
        // Pad below the LSB with ones so padding never adds to the
        // count of a nonzero mantissa.
        nz[0] = '1;
        nz[0][PAD_W-1 -: WIDTH] = mant;
        // Node i at level l covers 2^l bits; odd child is the upper half.
        for (int l = 1; l <= LVLS; l++) begin
            for (int i = 0; i < (PAD_W >> l); i++) begin
                nz[l][i] = nz[l-1][2*i+1] | nz[l-1][2*i];
                cnt[l][i] = nz[l-1][2*i+1] ? cnt[l-1][2*i+1]
                          : (cnt[l-1][2*i] | (LZC_W'(1) << (l - 1)));
            end
        end
        all_zero = ~|mant;
        lzc = all_zero ? '0 : cnt[LVLS][0];
    end

endmodule

// File: rtl/fp_normalize_pipe.sv
// Pipelined mantissa normaliser with exponent adjust and subnormal output.
// Ports: clk, rst_n, in_valid/in_ready/in_mant/in_exp, out_valid/out_ready,
// out_mant, out_exp, out_lzc, out_zero, out_underflow.
module fp_normalize_pipe
    import fp_norm_pkg::*;
#(
    parameter int WIDTH = 25,
    parameter int EXP_W = 8,
    parameter int PIPE  = 2,
    localparam int LZC_W = clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_mant,
    input  logic [EXP_W-1:0] in_exp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_mant,
    output logic [EXP_W-1:0] out_exp,
    output logic [LZC_W-1:0] out_lzc,
    output logic             out_zero,
    output logic             out_underflow
);

    localparam int CMP_W = (EXP_W > LZC_W ? EXP_W : LZC_W) + 1;

    typedef struct packed {
        logic [WIDTH-1:0] mant;
        logic [EXP_W-1:0] exp;
        logic [LZC_W-1:0] lzc;
        logic             zero;
    } payload_t;

    typedef struct packed {
        logic [WIDTH-1:0] mant;
        logic [EXP_W-1:0] exp;
        logic [LZC_W-1:0] lzc;
        logic             zero;
        logic             underflow;
    } result_t;

    function automatic result_t normalize(input payload_t p);
        result_t          r;
        logic [CMP_W-1:0] e;
        logic [CMP_W-1:0] lz;
        logic [LZC_W-1:0] sh;
        r = '0;
        e = CMP_W'(p.exp);
        lz = CMP_W'(p.lzc);
        sh = '0;
        r.zero = p.zero;
        r.lzc = p.lzc;
        if (!p.zero) begin
            if (e > lz) begin
                r.mant = p.mant << p.lzc;
                r.exp = p.exp - EXP_W'(p.lzc);
            end else begin
                // Subnormal: align so the biased-exponent-1 position
                // lands on the hidden bit; exp-1 < WIDTH here.
                if (p.exp != '0) sh = LZC_W'(p.exp - 1'b1);
                r.mant = p.mant << sh;
                r.underflow = 1'b1;
            end
        end
        return r;
    endfunction

    logic [LZC_W-1:0] in_lzc;
    logic             in_zero;
    payload_t         in_pl;

    lzc_tree #(
        .WIDTH(WIDTH),
        .LZC_W(LZC_W)
    ) u_lzc (
        .mant    (in_mant),
        .lzc     (in_lzc),
        .all_zero(in_zero)
    );

    assign in_pl = {in_mant, in_exp, in_lzc, in_zero};

    result_t  out_q;
    logic     out_v;
    logic     ready2;
    payload_t s2_src;
    logic     s2_src_v;

    assign ready2 = ~out_v | out_ready;

    generate
        if (PIPE == 2) begin : g_two
            payload_t s1_q;
            logic     s1_v;

            assign in_ready = ~s1_v | ready2;
            assign s2_src = s1_q;
            assign s2_src_v = s1_v;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    s1_v <= 1'b0;
                    s1_q <= '0;
                end else if (in_ready) begin
                    s1_v <= in_valid;
                    if (in_valid) s1_q <= in_pl;
                end
            end
        end else begin : g_one
            assign in_ready = ready2;
            assign s2_src = in_pl;
            assign s2_src_v = in_valid;
        end
    endgenerate

    // Data only loads with a valid beat so idle outputs keep their value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_v <= 1'b0;
            out_q <= '0;
        end else if (ready2) begin
            out_v <= s2_src_v;
            if (s2_src_v) out_q <= normalize(s2_src);
        end
    end

    assign out_valid     = out_v;
    assign out_mant      = out_q.mant;
    assign out_exp       = out_q.exp;
    assign out_lzc       = out_q.lzc;
    assign out_zero      = out_q.zero;
    assign out_underflow = out_q.underflow;

endmodule

// File: tb/tb_fp_normalize_pipe.sv
// Scoreboard bench for fp_normalize_pipe: PIPE=2 (index 0) and PIPE=1 (index 1).
// Directed vectors, a stalled burst per instance and a mid-flight reset.
module tb_fp_normalize_pipe;

    localparam int W  = 25;
    localparam int EW = 8;
    localparam int LW = 5;

    typedef struct packed {
        logic [W-1:0]  mant;
        logic [EW-1:0] exp;
        logic [LW-1:0] lzc;
        logic          zero;
        logic          uf;
    } res_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n = 1'b0;
    logic          in_valid  [2];
    logic          in_ready  [2];
    logic [W-1:0]  in_mant   [2];
    logic [EW-1:0] in_exp    [2];
    logic          out_valid [2];
    logic          out_ready [2];
    logic [W-1:0]  out_mant  [2];
    logic [EW-1:0] out_exp   [2];
    logic [LW-1:0] out_lzc   [2];
    logic          out_zero  [2];
    logic          out_uf    [2];

    int   n_vec = 0;
    int   n_bad = 0;
    res_t q0[$];
    res_t q1[$];

    logic [W-1:0]  vm [16];
    logic [EW-1:0] ve [16];

    fp_normalize_pipe #(.WIDTH(W), .EXP_W(EW), .PIPE(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_mant(in_mant[0]), .in_exp(in_exp[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_mant(out_mant[0]), .out_exp(out_exp[0]),
        .out_lzc(out_lzc[0]), .out_zero(out_zero[0]),
        .out_underflow(out_uf[0])
    );

    fp_normalize_pipe #(.WIDTH(W), .EXP_W(EW), .PIPE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_mant(in_mant[1]), .in_exp(in_exp[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_mant(out_mant[1]), .out_exp(out_exp[1]),
        .out_lzc(out_lzc[1]), .out_zero(out_zero[1]),
        .out_underflow(out_uf[1])
    );

    function automatic res_t got(input int d);
        return {out_mant[d], out_exp[d], out_lzc[d], out_zero[d], out_uf[d]};
    endfunction

    function automatic res_t model(input logic [W-1:0] m, input logic [EW-1:0] e);
        res_t r;
        int   lz;
        r = '0;
        lz = 0;
        if (m == '0) begin
            r.zero = 1'b1;
            return r;
        end
        while (!m[W-1-lz]) lz++;
        r.lzc = LW'(lz);
        if (int'(e) > lz) begin
            r.mant = m << lz;
            r.exp = e - EW'(lz);
        end else begin
            r.uf = 1'b1;
            r.mant = m << ((e == '0) ? 0 : int'(e) - 1);
        end
        return r;
    endfunction

    task automatic check(input string name, input res_t act, input res_t req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %b required %b", name, act, req);
        end
    endtask

    task automatic push(input int d, input res_t x);
        if (d == 0) q0.push_back(x);
        else q1.push_back(x);
    endtask

    task automatic monitor(input int d);
        res_t held;
        res_t e;
        logic stalled;
        held = '0;
        stalled = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                stalled = 1'b0;
                continue;
            end
            if (out_valid[d]) begin
                if (stalled) check($sformatf("hold%0d", d), got(d), held);
                if (out_ready[d]) begin
                    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                        n_vec++;
                        n_bad++;
                        $display("FAIL extra%0d: got %h required no beat", d, got(d));
                    end else begin
                        e = (d == 0) ? q0.pop_front() : q1.pop_front();
                        check($sformatf("result%0d", d), got(d), e);
                    end
                end
                stalled = !out_ready[d];
                held = got(d);
            end else begin
                stalled = 1'b0;
            end
        end
    endtask

    task automatic send(input int d, input logic [W-1:0] m,
                        input logic [EW-1:0] e, input res_t x);
        int guard;
        guard = 0;
        @(negedge clk);
        in_valid[d] = 1'b1;
        in_mant[d] = m;
        in_exp[d] = e;
        #1;
        while (!in_ready[d] && guard < 50) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (!in_ready[d]) begin
            n_vec++;
            n_bad++;
            $display("FAIL send_timeout%0d: got in_ready 0 required 1", d);
        end else begin
            push(d, x);
        end
        @(negedge clk);
        in_valid[d] = 1'b0;
    endtask

    task automatic stream(input int d);
        int i;
        int cyc;
        i = 0;
        cyc = 0;
        while (i < 16 && cyc < 200) begin
            @(negedge clk);
            out_ready[d] = !(cyc >= 5 && cyc <= 9);
            in_valid[d] = 1'b1;
            in_mant[d] = vm[i];
            in_exp[d] = ve[i];
            #1;
            if (cyc == 7)
                check_bit($sformatf("stall_in_ready%0d", d), in_ready[d], 1'b0);
            if (in_ready[d]) begin
                push(d, model(vm[i], ve[i]));
                i++;
            end
            cyc++;
        end
        if (i < 16) begin
            n_vec++;
            n_bad++;
            $display("FAIL stream_timeout%0d: got %0d beats required 16", d, i);
        end
        @(negedge clk);
        in_valid[d] = 1'b0;
        out_ready[d] = 1'b1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (q0.size() != 0 || q1.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: got %0d beats pending required 0",
                     q0.size() + q1.size());
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic check_idle(input string name, input int d);
        check_bit({name, "_out_valid"}, out_valid[d], 1'b0);
        check({name, "_data"}, got(d), '0);
        check_bit({name, "_in_ready"}, in_ready[d], 1'b1);
    endtask

    initial begin
        fork
            monitor(0);
            monitor(1);
        join_none
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            in_valid[d] = 1'b0;
            in_mant[d] = '0;
            in_exp[d] = '0;
            out_ready[d] = 1'b1;
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_idle("reset2", 0);
        check_idle("reset1", 1);

        // Latency: PIPE=2 shows the beat two edges after transfer, PIPE=1 one.
        send(0, 25'h1000000, 8'd127, {25'h1000000, 8'd127, 5'd0, 1'b0, 1'b0});
        #1;
        check_bit("lat2_early", out_valid[0], 1'b0);
        @(negedge clk);
        #1;
        check_bit("lat2_due", out_valid[0], 1'b1);
        send(1, 25'h1000000, 8'd127, {25'h1000000, 8'd127, 5'd0, 1'b0, 1'b0});
        #1;
        check_bit("lat1_due", out_valid[1], 1'b1);
        drain();

        for (int d = 0; d < 2; d++) begin
            send(d, 25'h0000001, 8'd100, {25'h1000000, 8'd76, 5'd24, 1'b0, 1'b0});
            send(d, 25'h0010000, 8'd5, {25'h0100000, 8'd0, 5'd8, 1'b0, 1'b1});
            send(d, 25'h0000000, 8'd200, {25'h0000000, 8'd0, 5'd0, 1'b1, 1'b0});
            send(d, 25'h0000100, 8'd16, {25'h0800000, 8'd0, 5'd16, 1'b0, 1'b1});
            send(d, 25'h0000100, 8'd17, {25'h1000000, 8'd1, 5'd16, 1'b0, 1'b0});
            send(d, 25'h0000100, 8'd0, {25'h0000100, 8'd0, 5'd16, 1'b0, 1'b1});
            send(d, 25'h1ffffff, 8'd255, {25'h1ffffff, 8'd255, 5'd0, 1'b0, 1'b0});
        end
        drain();

        for (int i = 0; i < 16; i++) begin
            vm[i] = W'($urandom) >> $urandom_range(0, 24);
            ve[i] = (i % 3 == 0) ? EW'($urandom_range(0, 24)) : EW'($urandom);
        end
        stream(0);
        drain();
        stream(1);
        drain();

        // Reset with two beats held inside the PIPE=2 instance.
        @(negedge clk);
        out_ready[0] = 1'b0;
        in_valid[0] = 1'b1;
        in_mant[0] = 25'h1000000;
        in_exp[0] = 8'd10;
        @(negedge clk);
        in_mant[0] = 25'h0000003;
        @(negedge clk);
        in_valid[0] = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        out_ready[0] = 1'b1;
        #1;
        check_idle("midreset", 0);
        send(0, 25'h0000100, 8'd20, {25'h1000000, 8'd4, 5'd16, 1'b0, 1'b0});
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
